axil_cmd_master: RTL and testbench
==================================

# axil_cmd_master

AXI4-Lite master that turns single-word command requests into AXI4-Lite write or read transactions and returns the slave's response. It sits between a local controller (sequencer, host-command decoder, boot-time config loader) and any of the design's AXI4-Lite register slaves, e.g. the core-control register blocks. It issues one transaction at a time; there are no outstanding-transaction overlaps.

## Interface
- TIMEOUT_CYCLES, 1024: cycles to wait for a slave handshake before aborting (used only with timeout compiled in).
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle, command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP from slave, or SLVERR (2) on timeout.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky; set on any timeout abort.
- M_AXI_AWADDR/AWVALID/AWPROT out, AWREADY in; M_AXI_WDATA/WVALID/WSTRB out, WREADY in; M_AXI_BRESP/BVALID in, BREADY out; M_AXI_ARADDR/ARVALID/ARPROT out, ARREADY in; M_AXI_RDATA/RRESP/RVALID in, RREADY out. Widths: addr/data 32, PROT 3, STRB 4, RESP 2.

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP, HALT (HALT only with timeout compiled in).
- IDLE: cmd_ready = 1. On accept, latch addr/wdata/write; go to WR_ADDR_DATA (write) or RD_ADDR (read).
- WR_ADDR_DATA: AWVALID and WVALID both asserted on entry; each deasserts on its own handshake independently, in either order or same cycle. When both handshakes are done, go to WR_RESP.
- WR_RESP: BREADY = 1; on BVALID, capture BRESP into rsp_resp, rsp_rdata = 0; go to RESP.
- RD_ADDR: ARVALID = 1 until ARREADY; then RD_DATA.
- RD_DATA: RREADY = 1; on RVALID, capture RDATA/RRESP; go to RESP.
- RESP: rsp_valid = 1, data held stable until rsp_ready; then IDLE.
- AWPROT = ARPROT = 0; WSTRB = 4'hF always. Address/data outputs stay stable while their VALID is high.
- BREADY/RREADY are asserted only in WR_RESP/RD_DATA; BVALID/RVALID arriving at any other time are not consumed.
- Reset mid-transaction: all VALIDs, READYs, rsp_valid drop on the reset cycle; state -> IDLE; timeout_err cleared.

## Timing
- Reset values: cmd_ready 0 while resetn = 0, 1 on the first cycle after; every other output 0.
- All outputs are registered except cmd_ready and busy (decoded from state).
- Command accepted at cycle N -> AWVALID/WVALID (or ARVALID) high at N+1.
- Zero-wait-state slave: write rsp_valid at N+3 (AW/W handshake N+1, B handshake N+2); read identical.
- B/R handshake at cycle M -> rsp_valid at M+1. rsp_ready at cycle K -> cmd_ready at K+1; next command may be accepted at K+1.
- No combinational path from any AXI input to any AXI output.

## Configuration
- AXIL_CMD_TIMEOUT_EN defined: a counter clears on entry to each of WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA and increments each cycle in that state. When it reaches TIMEOUT_CYCLES-1 without the awaited handshake: all VALID/READY drop next cycle, rsp_resp = 2, rsp_rdata = 0, timeout_err = 1, go to RESP; after the response is consumed go to HALT (cmd_ready = 0, busy = 1) until reset.
- Not defined: no counter, no HALT state, timeout_err tied 0; the block waits indefinitely.

## Test plan
- Write 0x0000_0028 <- 0x1234_5678, zero-wait slave, rsp_ready = 1 -> AWADDR 0x28, WDATA 0x12345678, WSTRB 0xF, rsp_valid at N+3, rsp_resp 0, rsp_rdata 0.
- Read 0x0000_0004, slave returns 0xDEAD_BEEF, RRESP 0 after 5 wait cycles -> rsp_rdata 0xDEADBEEF, rsp_resp 0, rsp_valid one cycle after R handshake.
- Write with WREADY 3 cycles before AWREADY, then the reverse, then same cycle -> exactly one AW and one W handshake each; BREADY is not asserted before both.
- Read of unmapped address, slave RRESP = 3; hold rsp_ready = 0 for 10 cycles -> rsp_resp 3 stable, cmd_ready 0 throughout, rsp_valid drops on consume.
- With AXIL_CMD_TIMEOUT_EN, TIMEOUT_CYCLES = 16, ARREADY never asserted -> ARVALID drops after 16 cycles, rsp_resp 2, timeout_err 1, cmd_ready stays 0 until resetn pulse.
- Assert resetn = 0 during WR_RESP -> BREADY, AWVALID, WVALID, rsp_valid 0 next edge; new read after release completes normally.

Source files
------------

// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-outstanding command master: one command in, one AXI transaction out, one response back.
// Optional slave-handshake timeout with sticky error and HALT is compiled in by defining AXIL_CMD_TIMEOUT_EN.
module axil_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  output logic [2:0]  M_AXI_AWPROT,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic        M_AXI_WVALID,
  output logic [3:0]  M_AXI_WSTRB,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
`ifdef AXIL_CMD_TIMEOUT_EN
    , HALT
`endif
  } state_t;

  state_t      state, state_nx;
  logic [31:0] addr, addr_nx, wdata, wdata_nx, rdata, rdata_nx;
  logic [1:0]  resp, resp_nx;
  logic        awvalid, awvalid_nx, wvalid, wvalid_nx, arvalid, arvalid_nx;
  logic        bready, bready_nx, rready, rready_nx, rsp_vld, rsp_vld_nx;

`ifdef AXIL_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             terr, terr_nx;
`endif

  always_comb begin
    state_nx   = state;
    addr_nx    = addr;
    wdata_nx   = wdata;
    rdata_nx   = rdata;
    resp_nx    = resp;
    awvalid_nx = awvalid;
    wvalid_nx  = wvalid;
    arvalid_nx = arvalid;
    bready_nx  = bready;
    rready_nx  = rready;
    rsp_vld_nx = rsp_vld;
`ifdef AXIL_CMD_TIMEOUT_EN
    cnt_nx     = '0;
    terr_nx    = terr;
`endif
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_nx  = cmd_addr;
          wdata_nx = cmd_wdata;
          if (cmd_write) begin
            state_nx   = WR_ADDR_DATA;
            awvalid_nx = 1'b1;
            wvalid_nx  = 1'b1;
          end else begin
            state_nx   = RD_ADDR;
            arvalid_nx = 1'b1;
          end
        end
      end
      WR_ADDR_DATA: begin
        // AW and W complete independently; leave only once both have handshaken
        if (M_AXI_AWREADY) awvalid_nx = 1'b0;
        if (M_AXI_WREADY)  wvalid_nx  = 1'b0;
        if ((!awvalid || M_AXI_AWREADY) && (!wvalid || M_AXI_WREADY)) begin
          state_nx  = WR_RESP;
          bready_nx = 1'b1;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          state_nx   = RESP;
          bready_nx  = 1'b0;
          rsp_vld_nx = 1'b1;
          resp_nx    = M_AXI_BRESP;
          rdata_nx   = '0;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_nx   = RD_DATA;
          arvalid_nx = 1'b0;
          rready_nx  = 1'b1;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          state_nx   = RESP;
          rready_nx  = 1'b0;
          rsp_vld_nx = 1'b1;
          resp_nx    = M_AXI_RRESP;
          rdata_nx   = M_AXI_RDATA;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_vld_nx = 1'b0;
`ifdef AXIL_CMD_TIMEOUT_EN
          state_nx   = terr ? HALT : IDLE;
`else
          state_nx   = IDLE;
`endif
        end
      end
      default: ;
    endcase
`ifdef AXIL_CMD_TIMEOUT_EN
    // Counter runs only while stalled in a handshake state; it restarts on every state change
    if ((state == WR_ADDR_DATA || state == WR_RESP || state == RD_ADDR || state == RD_DATA) &&
        state_nx == state) begin
      if (cnt == CNT_LAST) begin
        state_nx   = RESP;
        awvalid_nx = 1'b0;
        wvalid_nx  = 1'b0;
        arvalid_nx = 1'b0;
        bready_nx  = 1'b0;
        rready_nx  = 1'b0;
        rsp_vld_nx = 1'b1;
        resp_nx    = 2'd2;
        rdata_nx   = '0;
        terr_nx    = 1'b1;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      addr    <= '0;
      wdata   <= '0;
      rdata   <= '0;
      resp    <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
      bready  <= 1'b0;
      rready  <= 1'b0;
      rsp_vld <= 1'b0;
`ifdef AXIL_CMD_TIMEOUT_EN
      cnt     <= '0;
      terr    <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      wdata   <= wdata_nx;
      rdata   <= rdata_nx;
      resp    <= resp_nx;
      awvalid <= awvalid_nx;
      wvalid  <= wvalid_nx;
      arvalid <= arvalid_nx;
      bready  <= bready_nx;
      rready  <= rready_nx;
      rsp_vld <= rsp_vld_nx;
`ifdef AXIL_CMD_TIMEOUT_EN
      cnt     <= cnt_nx;
      terr    <= terr_nx;
`endif
    end
  end

  assign cmd_ready     = resetn && (state == IDLE);
  assign busy          = (state != IDLE);
`ifdef AXIL_CMD_TIMEOUT_EN
  assign timeout_err   = terr;
`else
  assign timeout_err   = 1'b0;
`endif
  assign rsp_valid     = rsp_vld;
  assign rsp_rdata     = rdata;
  assign rsp_resp      = resp;
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master with a configurable-latency AXI4-Lite slave.
// Define AXIL_CMD_TIMEOUT_EN to also exercise the timeout/HALT path (DUT built with TIMEOUT_CYCLES = 16).
module tb_axil_cmd_master;
`ifdef AXIL_CMD_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, busy, timeout_err;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

  axil_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .timeout_err(timeout_err),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  int compared = 0;
  int mismatched = 0;

  // Slave configuration, written by the test sequence only while no transaction is pending
  int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;

  // Handshake monitor: cumulative counts and captured payloads
  int          cyc = 0;
  int          aw_tot = 0, w_tot = 0, ar_tot = 0, b_tot = 0, r_tot = 0, bready_early = 0, r_hs_cyc = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [2:0]  cap_awprot = '0, cap_arprot = '0;

  always @(posedge clk) begin
    if (M_AXI_BREADY && !(aw_tot > b_tot && w_tot > b_tot)) bready_early <= bready_early + 1;
    if (M_AXI_AWVALID && M_AXI_AWREADY) begin
      aw_tot <= aw_tot + 1; cap_awaddr <= M_AXI_AWADDR; cap_awprot <= M_AXI_AWPROT;
    end
    if (M_AXI_WVALID && M_AXI_WREADY) begin
      w_tot <= w_tot + 1; cap_wdata <= M_AXI_WDATA; cap_wstrb <= M_AXI_WSTRB;
    end
    if (M_AXI_ARVALID && M_AXI_ARREADY) begin
      ar_tot <= ar_tot + 1; cap_araddr <= M_AXI_ARADDR; cap_arprot <= M_AXI_ARPROT;
    end
    if (M_AXI_BVALID && M_AXI_BREADY) b_tot <= b_tot + 1;
    if (M_AXI_RVALID && M_AXI_RREADY) begin
      r_tot <= r_tot + 1; r_hs_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  // Slave driver: READY after a per-channel delay, B/R after the request handshakes complete
  initial begin
    int aw_c, w_c, ar_c, b_c, r_c;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0; M_AXI_RVALID = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
    forever begin
      @(posedge clk); #1;
      if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_c >= aw_dly); aw_c++; end
      else begin M_AXI_AWREADY = 0; aw_c = 0; end
      if (M_AXI_WVALID) begin M_AXI_WREADY = (w_c >= w_dly); w_c++; end
      else begin M_AXI_WREADY = 0; w_c = 0; end
      if (M_AXI_ARVALID) begin M_AXI_ARREADY = (ar_c >= ar_dly); ar_c++; end
      else begin M_AXI_ARREADY = 0; ar_c = 0; end
      if (aw_tot > b_tot && w_tot > b_tot) begin
        M_AXI_BVALID = (b_c >= b_dly); M_AXI_BRESP = b_resp; b_c++;
      end else begin M_AXI_BVALID = 0; M_AXI_BRESP = 0; b_c = 0; end
      if (ar_tot > r_tot) begin
        M_AXI_RVALID = (r_c >= r_dly); M_AXI_RDATA = r_data; M_AXI_RRESP = r_resp; r_c++;
      end else begin M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; r_c = 0; end
    end
  end

  // Offer a command; n is the cycle in which it was accepted. Returns #1 into cycle n+1.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output int n, output bit ok);
    n = -1; ok = 0;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin n = cyc; ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int n, output bit ok);
    n = -1; ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin n = cyc; ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    compared++; if (cmd_ready !== 1'b0) begin mismatched++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    compared++;
    if ({busy, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, timeout_err} !== 8'h00) begin
      mismatched++; $display("FAIL rst_ctrl: got %b want 00000000",
        {busy, rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, timeout_err});
    end
    compared++; if ({rsp_rdata, rsp_resp, M_AXI_AWADDR} !== 66'h0) begin mismatched++; $display("FAIL rst_data: got %h want 0", {rsp_rdata, rsp_resp, M_AXI_AWADDR}); end
    resetn = 1;
    @(posedge clk); #1;
    compared++; if ({cmd_ready, busy} !== 2'b10) begin mismatched++; $display("FAIL rst_release: got %b want 10", {cmd_ready, busy}); end
  endtask

  task automatic test_write_basic();
    int n, r; bit ok;
    aw_dly = 0; w_dly = 0; b_dly = 0; b_resp = 0;
    issue(1'b1, 32'h0000_0028, 32'h1234_5678, n, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL wr_accept: got no accept want accept"); end
    compared++; if ({M_AXI_AWVALID, M_AXI_WVALID, cmd_ready, busy} !== 4'b1101) begin
      mismatched++; $display("FAIL wr_issue_n1: got %b want 1101", {M_AXI_AWVALID, M_AXI_WVALID, cmd_ready, busy}); end
    wait_rsp(r, ok);
    compared++; if (!ok || r !== n + 3) begin mismatched++; $display("FAIL wr_latency: got %0d want 3", r - n); end
    compared++; if (rsp_resp !== 2'd0 || rsp_rdata !== 32'h0) begin mismatched++; $display("FAIL wr_rsp: got %h/%h want 0/0", rsp_resp, rsp_rdata); end
    compared++; if (cap_awaddr !== 32'h28 || cap_awprot !== 3'd0) begin mismatched++; $display("FAIL wr_awaddr: got %h/%h want 28/0", cap_awaddr, cap_awprot); end
    compared++; if (cap_wdata !== 32'h1234_5678 || cap_wstrb !== 4'hF) begin mismatched++; $display("FAIL wr_wdata: got %h/%h want 12345678/f", cap_wdata, cap_wstrb); end
    @(posedge clk); #1;
    compared++; if ({cmd_ready, rsp_valid} !== 2'b10) begin mismatched++; $display("FAIL wr_consume: got %b want 10", {cmd_ready, rsp_valid}); end
  endtask

  task automatic test_read_wait();
    int n, r, a0; bit ok;
    ar_dly = 0; r_dly = 5; r_data = 32'hDEAD_BEEF; r_resp = 0; a0 = ar_tot;
    issue(1'b0, 32'h0000_0004, 32'h0, n, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL rd_accept: got no accept want accept"); end
    compared++; if ({M_AXI_ARVALID, M_AXI_AWVALID} !== 2'b10) begin mismatched++; $display("FAIL rd_issue_n1: got %b want 10", {M_AXI_ARVALID, M_AXI_AWVALID}); end
    wait_rsp(r, ok);
    compared++; if (!ok || r !== n + 8) begin mismatched++; $display("FAIL rd_latency: got %0d want 8", r - n); end
    compared++; if (r !== r_hs_cyc + 1) begin mismatched++; $display("FAIL rd_after_r: got %0d want %0d", r, r_hs_cyc + 1); end
    compared++; if (rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'd0) begin mismatched++; $display("FAIL rd_rsp: got %h/%h want deadbeef/0", rsp_rdata, rsp_resp); end
    compared++; if (cap_araddr !== 32'h4 || cap_arprot !== 3'd0 || ar_tot - a0 !== 1) begin
      mismatched++; $display("FAIL rd_ar: got %h/%h/%0d want 4/0/1", cap_araddr, cap_arprot, ar_tot - a0); end
  endtask

  task automatic test_write_skew();
    int awd[3]  = '{3, 0, 2};
    int wdl[3]  = '{0, 3, 2};
    int lat[3]  = '{6, 6, 5};
    logic [1:0] vv[3] = '{2'b10, 2'b01, 2'b11};
    int n, r, a0, w0, e0; bit ok;
    e0 = bready_early;
    for (int i = 0; i < 3; i++) begin
      aw_dly = awd[i]; w_dly = wdl[i]; b_dly = 0; b_resp = 2'(i);
      a0 = aw_tot; w0 = w_tot;
      issue(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), n, ok);
      @(posedge clk); #1;
      compared++; if (!ok || {M_AXI_AWVALID, M_AXI_WVALID} !== vv[i]) begin
        mismatched++; $display("FAIL skew%0d_valids_n2: got %b want %b", i, {M_AXI_AWVALID, M_AXI_WVALID}, vv[i]); end
      wait_rsp(r, ok);
      compared++; if (!ok || r !== n + lat[i]) begin mismatched++; $display("FAIL skew%0d_latency: got %0d want %0d", i, r - n, lat[i]); end
      compared++; if (aw_tot - a0 !== 1 || w_tot - w0 !== 1) begin
        mismatched++; $display("FAIL skew%0d_hs_count: got %0d/%0d want 1/1", i, aw_tot - a0, w_tot - w0); end
      compared++; if (rsp_resp !== 2'(i) || rsp_rdata !== 32'h0) begin
        mismatched++; $display("FAIL skew%0d_rsp: got %h/%h want %h/0", i, rsp_resp, rsp_rdata, 2'(i)); end
      compared++; if (cap_awaddr !== 32'h100 + 32'(4 * i) || cap_wdata !== 32'hA000_0000 + 32'(i)) begin
        mismatched++; $display("FAIL skew%0d_payload: got %h/%h", i, cap_awaddr, cap_wdata); end
      @(posedge clk); #1;
    end
    compared++; if (bready_early !== e0) begin mismatched++; $display("FAIL skew_bready_early: got %0d want 0", bready_early - e0); end
  endtask

  task automatic test_rsp_hold();
    int n, r; bit ok;
    ar_dly = 0; r_dly = 0; r_data = 32'h0; r_resp = 2'd3; rsp_ready = 0;
    issue(1'b0, 32'hFFFF_0000, 32'h0, n, ok);
    wait_rsp(r, ok);
    compared++; if (!ok || r !== n + 3) begin mismatched++; $display("FAIL hold_latency: got %0d want 3", r - n); end
    for (int i = 0; i < 10; i++) begin
      compared++; if ({rsp_valid, rsp_resp, cmd_ready} !== 4'b1110) begin
        mismatched++; $display("FAIL hold_cyc%0d: got %b want 1110", i, {rsp_valid, rsp_resp, cmd_ready}); end
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    compared++; if ({rsp_valid, cmd_ready} !== 2'b01) begin mismatched++; $display("FAIL hold_consume: got %b want 01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_reset_mid();
    int n, r, b0; bit ok, seen;
    aw_dly = 0; w_dly = 0; b_dly = 20; b_resp = 0;
    issue(1'b1, 32'h40, 32'h55AA_55AA, n, ok);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (M_AXI_BREADY) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    compared++; if (!seen) begin mismatched++; $display("FAIL mid_bready: got 0 want 1"); end
    resetn = 0;
    @(posedge clk); #1;
    compared++; if ({M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID, rsp_valid, busy, cmd_ready} !== 6'b0) begin
      mismatched++; $display("FAIL mid_reset: got %b want 000000",
        {M_AXI_BREADY, M_AXI_AWVALID, M_AXI_WVALID, rsp_valid, busy, cmd_ready}); end
    resetn = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (M_AXI_BVALID) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    b0 = b_tot;
    ar_dly = 0; r_dly = 0; r_data = 32'hA5A5_5A5A; r_resp = 0;
    issue(1'b0, 32'h10, 32'h0, n, ok);
    wait_rsp(r, ok);
    compared++; if (!ok || r !== n + 3) begin mismatched++; $display("FAIL mid_rd_latency: got %0d want 3", r - n); end
    compared++; if (rsp_rdata !== 32'hA5A5_5A5A || rsp_resp !== 2'd0) begin
      mismatched++; $display("FAIL mid_rd_rsp: got %h/%h want a5a55a5a/0", rsp_rdata, rsp_resp); end
    compared++; if (!seen || b_tot !== b0) begin mismatched++; $display("FAIL mid_stray_b: got seen=%b consumed=%0d want 1/0", seen, b_tot - b0); end
    @(posedge clk); #1;
  endtask

`ifdef AXIL_CMD_TIMEOUT_EN
  task automatic test_timeout();
    int n, k; bit ok;
    ar_dly = 100000; rsp_ready = 1; k = 0;
    issue(1'b0, 32'h80, 32'h0, n, ok);
    while (M_AXI_ARVALID && k < 100) begin k++; @(posedge clk); #1; end
    compared++; if (!ok || k !== 16) begin mismatched++; $display("FAIL to_arvalid_cycles: got %0d want 16", k); end
    compared++; if ({rsp_valid, rsp_resp, timeout_err} !== 4'b1101 || rsp_rdata !== 32'h0) begin
      mismatched++; $display("FAIL to_rsp: got %b/%h want 1101/0", {rsp_valid, rsp_resp, timeout_err}, rsp_rdata); end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      compared++; if ({cmd_ready, busy, timeout_err, rsp_valid} !== 4'b0110) begin
        mismatched++; $display("FAIL to_halt%0d: got %b want 0110", i, {cmd_ready, busy, timeout_err, rsp_valid}); end
      @(posedge clk); #1;
    end
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;
    compared++; if ({cmd_ready, busy, timeout_err} !== 3'b100) begin
      mismatched++; $display("FAIL to_reset: got %b want 100", {cmd_ready, busy, timeout_err}); end
  endtask
`endif

  initial begin
    resetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
    b_resp = 0; r_resp = 0; r_data = 0;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_write_skew();
    test_rsp_hold();
    test_reset_mid();
`ifdef AXIL_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
